// File: rtl/stdcell_test_sequencer.sv
// stdcell_test_sequencer
// Wishbone-programmable characterisation engine for standard cells. It sweeps
// every IN_W-bit input vector onto CHANNELS cells under test, waits a
// programmable settle time, and samples each cell's output. Each sample is
// compared against that channel's truth table. Mismatches are counted per
// channel in saturating error counters.
//
// Ports
//   wb_clk_i    single clock for all logic
//   wb_rst_ni   asynchronous active-low reset
//   wbs_*       Wishbone slave (full-word accesses, adr[7:2] decoded)
//   stim_o      registered stimulus, channel c at [c*IN_W +: IN_W]
//   resp_i      cell outputs, asynchronous to wb_clk_i
//   irq_o       completion interrupt (done & irq_en), level
//
// Register map (byte offsets)
//   0x00 CTRL    bit0 start (W1, self-clearing), bit1 abort (W1), bit2 irq_en
//   0x04 STATUS  bit0 busy, bit1 done, bit2 any_fail
//   0x08 SETTLE  [7:0], 0 behaves as 1
//   0x0C PASSES  [15:0], 0 = run until abort
//   0x10 VEC     [IN_W-1:0] vector, [31:16] pass count
//   0x40+4c TT[c], 0x80+4c ERR[c]
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | stimulus forced to 0, waiting for start
// S_APPLY  | drive current vector, load settle counter
// S_WAIT   | settle countdown (SETTLE+2 cycles, covers the synchroniser)
// S_SAMPLE | compare synchronised responses, bump error counters
// S_NEXT   | advance vector / pass, decide whether the run is complete
// S_DONE   | flag completion, return to idle
module stdcell_test_sequencer #(
  parameter int CHANNELS = 8,
  parameter int IN_W     = 4,
  parameter int CNT_W    = 16
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [CHANNELS*IN_W-1:0] stim_o,
  input  logic [CHANNELS-1:0]      resp_i,
  output logic                     irq_o
);

  localparam int TT_W = 1 << IN_W;

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_WAIT, S_SAMPLE, S_NEXT, S_DONE
  } state_t;

  state_t              state;
  logic [IN_W-1:0]     vec;
  logic [15:0]         pass_cnt;
  logic [8:0]          wait_cnt;
  logic                done;
  logic                irq_en;
  logic [7:0]          settle;
  logic [15:0]         passes;
  logic [TT_W-1:0]     tt  [CHANNELS];
  logic [CNT_W-1:0]    err [CHANNELS];
  logic [CHANNELS-1:0] resp_meta;
  logic [CHANNELS-1:0] resp_sync;

  logic        busy;
  logic        any_fail;
  logic [5:0]  reg_addr;
  logic        bus_req;
  logic        bus_wr;
  logic        start_req;
  logic        abort_req;
  logic [31:0] rdata;
  logic [7:0]  settle_eff;
  logic        unused_bits;

  assign busy        = (state != S_IDLE);
  assign reg_addr    = wbs_adr_i[7:2];
  assign bus_req     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign bus_wr      = bus_req & wbs_we_i;
  // abort takes priority, so a combined start|abort never launches a run
  assign abort_req   = bus_wr && (reg_addr == 6'd0) && wbs_dat_i[1];
  assign start_req   = bus_wr && (reg_addr == 6'd0) && wbs_dat_i[0] && !wbs_dat_i[1];
  assign settle_eff  = (settle == 8'd0) ? 8'd1 : settle;
  assign irq_o       = done & irq_en;
  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[31:8], wbs_adr_i[1:0], wbs_dat_i};

  always_comb begin
    any_fail = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      any_fail = any_fail | (err[c] != '0);
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_addr)
      6'd0: rdata[2]    = irq_en;
      6'd1: rdata[2:0]  = {any_fail, done, busy};
      6'd2: rdata[7:0]  = settle;
      6'd3: rdata[15:0] = passes;
      6'd4: begin
        rdata[IN_W-1:0] = vec;
        rdata[31:16]    = pass_cnt;
      end
      default: ;
    endcase
    for (int c = 0; c < CHANNELS; c++) begin
      if (reg_addr == 6'(16 + c)) rdata[TT_W-1:0]  = tt[c];
      if (reg_addr == 6'(32 + c)) rdata[CNT_W-1:0] = err[c];
    end
  end

  // Bus handshake: single-cycle ack, read data captured alongside it
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= bus_req;
      wbs_dat_o <= (bus_req && !wbs_we_i) ? rdata : 32'd0;
    end
  end

  // Configuration registers; sweep parameters are frozen while a run is active
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irq_en <= 1'b0;
      settle <= '0;
      passes <= '0;
      for (int c = 0; c < CHANNELS; c++) tt[c] <= '0;
    end else if (bus_wr) begin
      if (reg_addr == 6'd0) irq_en <= wbs_dat_i[2];
      if (!busy) begin
        if (reg_addr == 6'd2) settle <= wbs_dat_i[7:0];
        if (reg_addr == 6'd3) passes <= wbs_dat_i[15:0];
        for (int c = 0; c < CHANNELS; c++) begin
          if (reg_addr == 6'(16 + c)) tt[c] <= wbs_dat_i[TT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      resp_meta <= '0;
      resp_sync <= '0;
    end else begin
      resp_meta <= resp_i;
      resp_sync <= resp_meta;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state    <= S_IDLE;
      vec      <= '0;
      pass_cnt <= '0;
      wait_cnt <= '0;
      done     <= 1'b0;
      stim_o   <= '0;
      for (int c = 0; c < CHANNELS; c++) err[c] <= '0;
    end else if (abort_req && state != S_IDLE) begin
      state  <= S_IDLE;
      stim_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          stim_o <= '0;
          if (start_req) begin
            for (int c = 0; c < CHANNELS; c++) err[c] <= '0;
            done     <= 1'b0;
            vec      <= '0;
            pass_cnt <= '0;
            state    <= S_APPLY;
          end
        end
        S_APPLY: begin
          stim_o   <= {CHANNELS{vec}};
          // the extra two cycles let the response cross the synchroniser
          wait_cnt <= {1'b0, settle_eff} + 9'd2;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == 9'd1) state <= S_SAMPLE;
          else wait_cnt <= wait_cnt - 9'd1;
        end
        S_SAMPLE: begin
          for (int c = 0; c < CHANNELS; c++) begin
            if ((resp_sync[c] != tt[c][vec]) && (err[c] != {CNT_W{1'b1}}))
              err[c] <= err[c] + CNT_W'(1);
          end
          state <= S_NEXT;
        end
        S_NEXT: begin
          if (vec != {IN_W{1'b1}}) begin
            vec   <= vec + IN_W'(1);
            state <= S_APPLY;
          end else begin
            vec      <= '0;
            pass_cnt <= pass_cnt + 16'd1;
            if (passes != 16'd0 && (pass_cnt + 16'd1) == passes) state <= S_DONE;
            else state <= S_APPLY;
          end
        end
        S_DONE: begin
          done   <= 1'b1;
          stim_o <= '0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stdcell_test_sequencer.sv
module tb_stdcell_test_sequencer;
  localparam int CH = 8;
  localparam int IW = 4;
  localparam int CW = 4;
  localparam int NV = 1 << IW;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]    sel = 4'hF;
  logic [31:0]   adr = '0, wdat = '0;
  logic          ack;
  logic [31:0]   rdat;
  logic [CH*IW-1:0] stim;
  logic [CH-1:0] resp;
  logic          irq;

  // behavioural cells: each channel is an arbitrary truth table of its inputs
  logic [NV-1:0] cell_tt [CH];

  int n_checks = 0;
  int n_fails  = 0;

  stdcell_test_sequencer #(.CHANNELS(CH), .IN_W(IW), .CNT_W(CW)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .stim_o(stim), .resp_i(resp), .irq_o(irq)
  );

  always #5 clk = ~clk;

  always_comb begin
    resp = '0;
    for (int c = 0; c < CH; c++) resp[c] = cell_tt[c][stim[c*IW +: IW]];
  end

  task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] q, output int lat);
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = {24'd0, a}; wdat = d;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ack) break;
    end
    if (!ack) begin
      $display("FAIL bus_timeout addr=%h: no ack, required ack within 20 cycles", a);
      $fatal(1, "bus timeout");
    end
    q = rdat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] q; int lat;
    bus(1'b1, a, d, q, lat);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] q);
    int lat;
    bus(1'b0, a, 32'd0, q, lat);
  endtask

  task automatic wait_irq(input int budget, output int cycles);
    cycles = 0;
    while (!irq && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  // busy time = passes * vectors * (settle + 5), plus the one-cycle DONE state
  function automatic int run_cycles(input int settle, input int passes);
    int s;
    s = (settle == 0) ? 1 : settle;
    return passes * NV * (s + 5) + 1;
  endfunction

  function automatic int exp_err(input int mism_per_pass, input int passes);
    int e;
    e = mism_per_pass * passes;
    return (e > SAT) ? SAT : e;
  endfunction

  task automatic test_reset;
    logic [31:0] q; int lat;
    logic [7:0] addrs [$];
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (stim !== '0) begin n_fails++; $display("FAIL reset_stim got=%h exp=0", stim); end
    n_checks++; if (ack !== 1'b0) begin n_fails++; $display("FAIL reset_ack got=%b exp=0", ack); end
    n_checks++; if (irq !== 1'b0) begin n_fails++; $display("FAIL reset_irq got=%b exp=0", irq); end
    rst_n = 1'b1;
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20};
    for (int c = 0; c < CH; c++) begin
      addrs.push_back(8'(8'h40 + 4*c));
      addrs.push_back(8'(8'h80 + 4*c));
    end
    foreach (addrs[i]) begin
      bus(1'b0, addrs[i], 32'd0, q, lat);
      n_checks++; if (q !== 32'd0) begin n_fails++; $display("FAIL reset_read addr=%h got=%h exp=0", addrs[i], q); end
      n_checks++; if (lat !== 1) begin n_fails++; $display("FAIL ack_latency addr=%h got=%0d exp=1", addrs[i], lat); end
    end
    bus(1'b1, 8'h24, 32'hFFFF_FFFF, q, lat);
    n_checks++; if (lat !== 1) begin n_fails++; $display("FAIL unmapped_write_ack got=%0d exp=1", lat); end
  endtask

  task automatic test_and_gate;
    logic [31:0] q; int cyc_n;
    cell_tt[0] = 16'h8888;
    wr(8'h40, 32'h8888);
    wr(8'h08, 32'd1);
    wr(8'h0C, 32'd3);
    wr(8'h00, 32'h5);
    wait_irq(1000, cyc_n);
    n_checks++; if (cyc_n !== run_cycles(1, 3)) begin n_fails++; $display("FAIL and_cycles got=%0d exp=%0d", cyc_n, run_cycles(1, 3)); end
    rd(8'h04, q);
    n_checks++; if (q !== 32'h2) begin n_fails++; $display("FAIL and_status got=%h exp=2", q); end
    rd(8'h80, q);
    n_checks++; if (q !== 32'd0) begin n_fails++; $display("FAIL and_err0 got=%0d exp=0", q); end
    rd(8'h10, q);
    n_checks++; if (q !== 32'h0003_0000) begin n_fails++; $display("FAIL and_vec got=%h exp=00030000", q); end
  endtask

  task automatic test_stuck;
    logic [31:0] q; int cyc_n;
    cell_tt[0] = '0;
    wr(8'h00, 32'h5);
    rd(8'h04, q);
    n_checks++; if (q[1:0] !== 2'b01) begin n_fails++; $display("FAIL stuck_started got=%b exp=01", q[1:0]); end
    wait_irq(1000, cyc_n);
    rd(8'h80, q);
    n_checks++; if (q !== 32'(exp_err(4, 3))) begin n_fails++; $display("FAIL stuck_err0 got=%0d exp=%0d", q, exp_err(4, 3)); end
    rd(8'h04, q);
    n_checks++; if (q !== 32'h6) begin n_fails++; $display("FAIL stuck_status got=%h exp=6", q); end
    n_checks++; if (irq !== 1'b1) begin n_fails++; $display("FAIL stuck_irq got=%b exp=1", irq); end
    wr(8'h00, 32'h0);
    n_checks++; if (irq !== 1'b0) begin n_fails++; $display("FAIL irq_mask got=%b exp=0", irq); end
  endtask

  task automatic test_abort_saturation;
    logic [31:0] q;
    cell_tt[0] = 16'h8888;
    cell_tt[1] = '0;
    wr(8'h44, 32'hFFFF);
    wr(8'h0C, 32'd0);
    wr(8'h00, 32'h5);
    repeat (2 * NV * 6 + 10) @(posedge clk);
    rd(8'h10, q);
    n_checks++; if (q[31:16] < 16'd2) begin n_fails++; $display("FAIL cont_passes got=%0d exp>=2", q[31:16]); end
    wr(8'h00, 32'h6);
    n_checks++; if (stim !== '0) begin n_fails++; $display("FAIL abort_stim got=%h exp=0", stim); end
    n_checks++; if (irq !== 1'b0) begin n_fails++; $display("FAIL abort_irq got=%b exp=0", irq); end
    rd(8'h04, q);
    n_checks++; if (q !== 32'h4) begin n_fails++; $display("FAIL abort_status got=%h exp=4", q); end
    rd(8'h84, q);
    n_checks++; if (q !== 32'(SAT)) begin n_fails++; $display("FAIL sat_err1 got=%0d exp=%0d", q, SAT); end
    rd(8'h80, q);
    n_checks++; if (q !== 32'd0) begin n_fails++; $display("FAIL abort_err0 got=%0d exp=0", q); end
  endtask

  task automatic test_busy_protect;
    logic [31:0] q;
    cell_tt[1] = 16'hFFFF;
    wr(8'h00, 32'h1);
    repeat (NV * 6 + 20) @(posedge clk);
    wr(8'h40, 32'h1234);
    rd(8'h40, q);
    n_checks++; if (q !== 32'h8888) begin n_fails++; $display("FAIL tt_locked got=%h exp=8888", q); end
    wr(8'h08, 32'd9);
    rd(8'h08, q);
    n_checks++; if (q !== 32'd1) begin n_fails++; $display("FAIL settle_locked got=%0d exp=1", q); end
    wr(8'h00, 32'h1);
    rd(8'h10, q);
    n_checks++; if (q[31:16] < 16'd1) begin n_fails++; $display("FAIL no_restart pass got=%0d exp>=1", q[31:16]); end
    wr(8'h00, 32'h2);
    wr(8'h00, 32'h3);
    rd(8'h04, q);
    n_checks++; if (q[0] !== 1'b0) begin n_fails++; $display("FAIL start_abort_busy got=%b exp=0", q[0]); end
  endtask

  task automatic test_random;
    logic [31:0] q; int cyc_n, settle, passes;
    int mism [CH];
    logic [NV-1:0] t, m;
    bit any;
    for (int it = 0; it < 4; it++) begin
      settle = $urandom_range(0, 3);
      passes = $urandom_range(1, 2);
      any = 1'b0;
      for (int c = 0; c < CH; c++) begin
        t = NV'($urandom);
        m = NV'($urandom & $urandom & $urandom);
        cell_tt[c] = t ^ m;
        mism[c] = $countones(m);
        if (mism[c] != 0) any = 1'b1;
        wr(8'(8'h40 + 4*c), 32'(t));
      end
      wr(8'h08, 32'(settle));
      wr(8'h0C, 32'(passes));
      wr(8'h00, 32'h5);
      wait_irq(2000, cyc_n);
      n_checks++; if (cyc_n !== run_cycles(settle, passes)) begin n_fails++; $display("FAIL rand_cycles it=%0d got=%0d exp=%0d", it, cyc_n, run_cycles(settle, passes)); end
      for (int c = 0; c < CH; c++) begin
        rd(8'(8'h80 + 4*c), q);
        n_checks++; if (q !== 32'(exp_err(mism[c], passes))) begin n_fails++; $display("FAIL rand_err it=%0d ch=%0d got=%0d exp=%0d", it, c, q, exp_err(mism[c], passes)); end
      end
      rd(8'h04, q);
      n_checks++; if (q !== {29'd0, any, 2'b10}) begin n_fails++; $display("FAIL rand_status it=%0d got=%h exp=%h", it, q, {29'd0, any, 2'b10}); end
    end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] q; int cyc_n;
    for (int c = 0; c < CH; c++) cell_tt[c] = '0;
    cell_tt[2] = 16'hFFFF;
    for (int c = 0; c < CH; c++) wr(8'(8'h40 + 4*c), 32'd0);
    wr(8'h08, 32'd5);
    wr(8'h0C, 32'd1);
    wr(8'h00, 32'h5);
    // vector 1 is applied at cycle 11 and settles until cycle 18
    repeat (13) begin @(posedge clk); #1; end
    n_checks++; if (stim !== {CH{4'h1}}) begin n_fails++; $display("FAIL mid_stim got=%h exp=%h", stim, {CH{4'h1}}); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (stim !== '0) begin n_fails++; $display("FAIL rst_stim got=%h exp=0", stim); end
    n_checks++; if (ack !== 1'b0) begin n_fails++; $display("FAIL rst_ack got=%b exp=0", ack); end
    n_checks++; if (irq !== 1'b0) begin n_fails++; $display("FAIL rst_irq got=%b exp=0", irq); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd(8'h04, q);
    n_checks++; if (q !== 32'd0) begin n_fails++; $display("FAIL rst_status got=%h exp=0", q); end
    rd(8'h88, q);
    n_checks++; if (q !== 32'd0) begin n_fails++; $display("FAIL rst_err2 got=%0d exp=0", q); end
    rd(8'h08, q);
    n_checks++; if (q !== 32'd0) begin n_fails++; $display("FAIL rst_settle got=%0d exp=0", q); end
    cell_tt[2] = '0;
    wr(8'h0C, 32'd1);
    wr(8'h00, 32'h5);
    wait_irq(1000, cyc_n);
    n_checks++; if (cyc_n !== run_cycles(0, 1)) begin n_fails++; $display("FAIL fresh_cycles got=%0d exp=%0d", cyc_n, run_cycles(0, 1)); end
    rd(8'h04, q);
    n_checks++; if (q !== 32'h2) begin n_fails++; $display("FAIL fresh_status got=%h exp=2", q); end
  endtask

  initial begin
    for (int c = 0; c < CH; c++) cell_tt[c] = '0;
    test_reset();
    test_and_gate();
    test_stuck();
    test_abort_saturation();
    test_busy_protect();
    test_random();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/stdcell_test_sequencer.md
Name: stdcell_test_sequencer

Overview:
- Parametrised, Wishbone-programmable test engine for standard-cell characterisation, replacing hard-wired cell-to-pad hookups.
- Drives an exhaustive input-vector sweep onto CHANNELS cells under test and samples each cell's output after a programmable settle time.
- Compares each sample against a per-channel truth table held in registers and keeps a saturating per-channel error count.
- Sits in the user project area, between the Wishbone slave port and the cell-under-test array.

Parameters:
- CHANNELS, 8, number of cells under test; legal range 1..16.
- IN_W, 4, input vector width shared by all channels; legal range 1..5, so a truth table (2^IN_W bits) fits one word.
- CNT_W, 16, per-channel error counter width; legal range 1..32.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  byte selects; ignored, all accesses are full-word.
- wbs_adr_i  in  32  address; only bits [7:2] are decoded.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- stim_o  out  CHANNELS*IN_W  registered stimulus; channel c occupies bits [c*IN_W +: IN_W].
- resp_i  in  CHANNELS  cell outputs; treated as asynchronous.
- irq_o  out  1  completion interrupt.

Behaviour:
- Reset: all registers, counters, wbs_ack_o, wbs_dat_o, stim_o and irq_o go to 0; FSM enters IDLE.
- Wishbone timing: wbs_ack_o pulses for one cycle, one cycle after stb&cyc is seen with ack low. Read data is valid with ack. Unmapped reads return 0 and are acked; unmapped writes are ignored and acked.
- Register map (byte offsets):
  - 0x00 CTRL: bit0 start (write-1, self-clearing); bit1 abort (write-1, self-clearing); bit2 irq_en (RW).
  - 0x04 STATUS (RO): bit0 busy; bit1 done (sticky, cleared by start); bit2 any_fail (OR of all ERR != 0).
  - 0x08 SETTLE[7:0] (RW). A value of 0 is treated as 1.
  - 0x0C PASSES[15:0] (RW). 0 means run continuously until abort.
  - 0x10 VEC (RO): current vector in [IN_W-1:0]; pass count in [31:16].
  - 0x40+4c TT[c] (RW), [2^IN_W-1:0]: expected output for vector v is bit v.
  - 0x80+4c ERR[c] (RO), [CNT_W-1:0].
- Writes to SETTLE, PASSES and TT while busy are ignored.
- start while busy is ignored. start and abort in the same write: abort wins, block stays IDLE.
- resp_i passes through a 2-flop synchroniser per bit.
- FSM:
  - IDLE: stim_o = 0. On start: clear all ERR, clear done, vec = 0, pass = 0, go to APPLY.
  - APPLY (1 cycle): stim_o <= vec replicated on every channel; load settle counter with SETTLE+2; go to WAIT.
  - WAIT (SETTLE+2 cycles): count down, then go to SAMPLE.
  - SAMPLE (1 cycle): for each c, if resp_sync[c] != TT[c][vec], increment ERR[c], saturating at 2^CNT_W-1.
  - NEXT (1 cycle):
    - If vec is not 2^IN_W-1: vec++, go to APPLY.
    - Otherwise: vec = 0, pass++. If PASSES != 0 and pass == PASSES, go to DONE; else go to APPLY.
    - Pass counter is 16 bits and wraps.
  - DONE (1 cycle): set done, go to IDLE.
- Per-vector cost is SETTLE+5 cycles (SETTLE >= 1).
- busy = (state != IDLE).
- abort in any non-IDLE state: IDLE on the next cycle, stim_o = 0, done not set, ERR retained.
- irq_o = done & irq_en, a level signal.
- Reset asserted mid-run: immediate return to reset values; no partial results are retained.

Test Plan:
- Reset, then read all registers: every value is 0; stim_o = 0; each access acked exactly one cycle after stb.
- Channel 0 modelled as AND of stim bits 0 and 1; TT0 = 0x8888, SETTLE = 1, PASSES = 3, start. Required: busy for 288 cycles, then done = 1, ERR0 = 0, any_fail = 0.
- Same setup but resp_i[0] stuck at 0. Required: ERR0 = 12 (4 per pass), any_fail = 1, irq_o = 1 when irq_en = 1.
- CNT_W = 4, TT1 = 0xFFFF, resp_i[1] = 0, PASSES = 0; after 2 passes write abort. Required: ERR1 = 15 (saturated), busy = 0 on the next cycle, done = 0, stim_o = 0.
- Write TT0 = 0x1234 while busy: readback shows the old value. Start while busy: no restart, VEC keeps advancing. start|abort in one write from IDLE: busy stays 0.
- Drive wb_rst_ni low during WAIT: stim_o, ERR, STATUS and wbs_ack_o are all 0 immediately. After release, a fresh run completes normally.
